// File: rtl/n64adv2_rst_sequencer_pkg.sv
// rtl/n64adv2_rst_sequencer_pkg.sv - state encodings, reset source IDs and fixed-priority grant helpers
package n64adv2_rst_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ALIGN    = 3'd1,
        ST_ASSERT   = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_EXTERN   = 3'd4
    } rstseq_state_t;

    typedef logic [1:0] rstsrc_t;

    localparam rstsrc_t RSTSRC_IGR  = 2'd0;
    localparam rstsrc_t RSTSRC_CPU  = 2'd1;
    localparam rstsrc_t RSTSRC_AUX  = 2'd2;
    localparam rstsrc_t RSTSRC_NONE = 2'd3;

    // Lowest index wins; RSTSRC_NONE when nothing is eligible.
    function automatic rstsrc_t prio_src(input logic [2:0] eligible);
        if (eligible[0])
            return RSTSRC_IGR;
        else if (eligible[1])
            return RSTSRC_CPU;
        else if (eligible[2])
            return RSTSRC_AUX;
        else
            return RSTSRC_NONE;
    endfunction

    function automatic logic [2:0] src_onehot(input rstsrc_t src);
        case (src)
            RSTSRC_IGR: return 3'b001;
            RSTSRC_CPU: return 3'b010;
            RSTSRC_AUX: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/n64adv2_rst_sequencer_sync.sv
// rtl/n64adv2_rst_sequencer_sync.sv - two-flop synchronizer with configurable reset preset
module n64adv2_rst_sequencer_sync #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] reg_i,
    output logic [WIDTH-1:0] reg_o
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta  <= RESET_VAL;
            reg_o <= RESET_VAL;
        end else begin
            meta  <= reg_i;
            reg_o <= meta;
        end
    end

endmodule

// File: rtl/n64adv2_rst_sequencer.sv
// rtl/n64adv2_rst_sequencer.sv - N64 reset request arbiter/sequencer; vsync alignment under N64ADV2_RST_VSYNC_ALIGN_EN
module n64adv2_rst_sequencer
    import n64adv2_rst_sequencer_pkg::*;
#(
    parameter logic [23:0] HOLD_CYCLES     = 24'd11_200_000,
    parameter logic [23:0] COOLDOWN_CYCLES = 24'd4_870_000,
    parameter logic [20:0] ALIGN_TIMEOUT   = 21'd1_200_000
) (
    input  logic       N64_CLK_i,
    input  logic       CTRL_nRST,
    input  logic [2:0] req_i,
    input  logic [2:0] enable_i,
    input  logic       nVSYNC_i,
    input  logic       rst_sense_i,
    output logic       rst_drv_o,
    output logic [2:0] ack_o,
    output logic       busy_o,
    output logic       ext_rst_o,
    output logic [1:0] src_o
);

    localparam logic [23:0] HOLD_LOAD = HOLD_CYCLES - 24'd1;
    localparam logic [23:0] COOL_LOAD = COOLDOWN_CYCLES - 24'd1;

    rstseq_state_t state;
    logic [23:0]   cnt;
    logic [2:0]    armed;
    logic          sense_s;

    logic [2:0]    eligible;
    rstsrc_t       grant_src;
    logic [2:0]    grant_mask;
    logic          take_grant;

    n64adv2_rst_sequencer_sync #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sense_sync (
        .clk   (N64_CLK_i),
        .nrst  (CTRL_nRST),
        .reg_i (rst_sense_i),
        .reg_o (sense_s)
    );

`ifdef N64ADV2_RST_VSYNC_ALIGN_EN
    localparam logic [23:0] ALIGN_LOAD = {3'd0, ALIGN_TIMEOUT} - 24'd1;

    logic nvsync_q;
    logic vs_fall_q;

    always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
        if (!CTRL_nRST) begin
            nvsync_q  <= 1'b1;
            vs_fall_q <= 1'b0;
        end else begin
            nvsync_q  <= nVSYNC_i;
            vs_fall_q <= nvsync_q & ~nVSYNC_i;
        end
    end
`else
    logic unused_align;
    assign unused_align = ^{nVSYNC_i, ALIGN_TIMEOUT};
`endif

    // A requester re-arms only after its request has been seen low, so a held level cannot retrigger.
    assign eligible   = req_i & enable_i & armed;
    assign grant_src  = prio_src(eligible);
    assign grant_mask = src_onehot(grant_src);
    assign take_grant = (state == ST_IDLE) && sense_s && (|eligible);

    always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
        if (!CTRL_nRST) begin
            state     <= ST_IDLE;
            cnt       <= 24'd0;
            armed     <= 3'b000;
            src_o     <= RSTSRC_NONE;
            rst_drv_o <= 1'b0;
            ack_o     <= 3'b000;
            busy_o    <= 1'b0;
            ext_rst_o <= 1'b0;
        end else begin
            ack_o <= 3'b000;
            armed <= (armed | ~req_i) & ~(take_grant ? grant_mask : 3'b000);

            case (state)
                ST_IDLE: begin
                    if (!sense_s) begin
                        state     <= ST_EXTERN;
                        ext_rst_o <= 1'b1;
                        busy_o    <= 1'b1;
                    end else if (take_grant) begin
                        src_o  <= grant_src;
                        busy_o <= 1'b1;
`ifdef N64ADV2_RST_VSYNC_ALIGN_EN
                        state  <= ST_ALIGN;
                        cnt    <= ALIGN_LOAD;
`else
                        state     <= ST_ASSERT;
                        cnt       <= HOLD_LOAD;
                        rst_drv_o <= 1'b1;
`endif
                    end
                end

`ifdef N64ADV2_RST_VSYNC_ALIGN_EN
                ST_ALIGN: begin
                    if (vs_fall_q || cnt == 24'd0) begin
                        state     <= ST_ASSERT;
                        cnt       <= HOLD_LOAD;
                        rst_drv_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 24'd1;
                    end
                end
`endif

                ST_ASSERT: begin
                    if (cnt == 24'd0) begin
                        state     <= ST_COOLDOWN;
                        cnt       <= COOL_LOAD;
                        rst_drv_o <= 1'b0;
                        ack_o     <= src_onehot(src_o);
                    end else begin
                        cnt <= cnt - 24'd1;
                    end
                end

                ST_COOLDOWN: begin
                    if (cnt == 24'd0) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt - 24'd1;
                    end
                end

                // User is holding the console reset; wait for release, then lock out like our own reset.
                ST_EXTERN: begin
                    if (sense_s) begin
                        state     <= ST_COOLDOWN;
                        cnt       <= COOL_LOAD;
                        ext_rst_o <= 1'b0;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    cnt       <= 24'd0;
                    rst_drv_o <= 1'b0;
                    busy_o    <= 1'b0;
                    ext_rst_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
